sram_result_reader: RTL and testbench
=====================================

SRAM_RESULT_READER -- requirements
Module: sram_result_reader

Interface
REQ-001 Parameter A_INIT_WIDTH, default 11, word-address width of the P memory port B.
REQ-002 Parameter D_INIT_WIDTH, default 32, data width of the P memory port B.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  synchronous, active-low reset.
REQ-005 Go  input  1  single-cycle start pulse, sampled only in IDLE.
REQ-006 Busy  output  1  high from the cycle after an accepted Go until Done.
REQ-007 Done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-008 P_Addr  output  A_INIT_WIDTH  port B read address to P memory.
REQ-009 P_En  output  1  port B enable to P memory.
REQ-010 P_We  output  1  port B write enable, tied 0 (read-only master).
REQ-011 P_In  input  D_INIT_WIDTH  port B read data, valid the cycle after the edge sampling P_En=1.
REQ-012 Out_Data  output  D_INIT_WIDTH  streamed word.
REQ-013 Out_Addr  output  A_INIT_WIDTH  address the streamed word was read from.
REQ-014 Out_Valid  output  1  Out_Data/Out_Addr hold a word.
REQ-015 Out_Ready  input  1  consumer accepts word when Out_Valid and Out_Ready are both high at a rising edge.

Function
REQ-016 The block SHALL read every P address 0 .. 2**A_INIT_WIDTH-1 exactly once, in ascending order, and stream each word out in the same order.
REQ-017 States SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on Go=1; RUN->DRAIN once the read of the last address is issued; DRAIN->DONE when the buffer is empty and no read is in flight; DONE->IDLE unconditionally the next cycle.
REQ-018 Done SHALL be high only in DONE; Busy SHALL be high in RUN and DRAIN.
REQ-019 Go while not in IDLE SHALL be ignored.
REQ-020 Data returned by P memory SHALL be captured into a 2-entry FIFO, tagged with the address issued one cycle earlier.
REQ-021 A read SHALL be issued (P_En=1) in RUN only if FIFO occupancy + in-flight reads - (pop this cycle) < 2, guaranteeing no overflow under any Out_Ready pattern.
REQ-022 The read address counter SHALL increment by 1 per issued read and SHALL NOT wrap; no read is issued after the last address.
REQ-023 With Out_Ready held 1, sustained throughput SHALL be one word per cycle; first Out_Valid SHALL rise 2 cycles after the Go edge (issue, capture).
REQ-024 Out_Valid SHALL stay high and Out_Data/Out_Addr SHALL stay stable until accepted.
REQ-025 Simultaneous push and pop on the FIFO SHALL keep occupancy unchanged and preserve order.
REQ-026 P_Addr SHALL hold its last value when P_En=0; P_We SHALL be 0 always.

Reset
REQ-027 Rst=0 at a rising edge SHALL force state IDLE, Busy=0, Done=0, P_En=0, P_We=0, P_Addr=0, Out_Valid=0, Out_Data=0, Out_Addr=0, FIFO empty, in-flight flag cleared.
REQ-028 Reset during RUN or DRAIN SHALL abort the sweep; data returning the cycle after reset SHALL be discarded; the next Go SHALL restart at address 0.

Verification
REQ-029 P preloaded with P[i]=i*0x01010101 (32-bit wrap), Out_Ready=1, Go pulse -> 2048 words, Out_Addr 0..2047, Out_Data matches, one word/cycle, Done exactly once, 2049 cycles after first Out_Valid at most.
REQ-030 Out_Ready toggling 1-0-1-0 and random 30% duty -> same 2048-word sequence, no loss/duplicate, Out_Data stable while Out_Valid=1 and Out_Ready=0.
REQ-031 Out_Ready=0 for 100 cycles after Go -> P_En stops after at most 2 reads, Out_Addr stays 0, resumes correctly when Out_Ready=1.
REQ-032 Go pulsed again at word 500 -> ignored; sweep completes once, single Done.
REQ-033 Rst=0 for one cycle at word 1000 -> all outputs at REQ-027 values next cycle; new Go -> full sweep from address 0, 2048 words.
REQ-034 Last-word boundary: P[2047]=0xDEADBEEF -> final word Out_Addr=0x7FF, Out_Data=0xDEADBEEF, no P_En after address 0x7FF, Done one cycle after its acceptance.

Source files
------------

// File: rtl/sram_result_reader_if.sv
// Port-B read bus to P memory plus the valid/ready result stream.
// The reader drives the master side; memory and consumer sit on the slave side.
interface sram_result_reader_if #(
  parameter int A_INIT_WIDTH = 11,
  parameter int D_INIT_WIDTH = 32
);
  logic [A_INIT_WIDTH-1:0] P_Addr;
  logic                    P_En;
  logic                    P_We;
  logic [D_INIT_WIDTH-1:0] P_In;

  logic [D_INIT_WIDTH-1:0] Out_Data;
  logic [A_INIT_WIDTH-1:0] Out_Addr;
  logic                    Out_Valid;
  logic                    Out_Ready;

  modport master (
    output P_Addr,
    output P_En,
    output P_We,
    input  P_In,
    output Out_Data,
    output Out_Addr,
    output Out_Valid,
    input  Out_Ready
  );

  modport slave (
    input  P_Addr,
    input  P_En,
    input  P_We,
    output P_In,
    input  Out_Data,
    input  Out_Addr,
    input  Out_Valid,
    output Out_Ready
  );
endinterface

// File: rtl/sram_result_reader.sv
// Sweeps every P memory word in ascending order and streams it out
// through a 2-entry FIFO tagged with the address it came from.
module sram_result_reader #(
  parameter int A_INIT_WIDTH = 11,
  parameter int D_INIT_WIDTH = 32
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Go,
  output logic Busy,
  output logic Done,
  sram_result_reader_if.master bus
);

  localparam logic [A_INIT_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [A_INIT_WIDTH-1:0] addr;
    logic [D_INIT_WIDTH-1:0] data;
  } entry_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [A_INIT_WIDTH-1:0] addr_q;
  logic [A_INIT_WIDTH-1:0] addr_d;
  logic [A_INIT_WIDTH-1:0] p_addr_q;
  logic [A_INIT_WIDTH-1:0] p_addr_d;
  logic                    inflight_q;
  logic                    inflight_d;
  entry_t                  fifo_q [2];
  entry_t                  fifo_d [2];
  logic                    wr_ptr_q;
  logic                    wr_ptr_d;
  logic                    rd_ptr_q;
  logic                    rd_ptr_d;
  logic [1:0]              cnt_q;
  logic [1:0]              cnt_d;

  logic                    pop;
  logic                    push;
  logic                    issue;
  logic [2:0]              occ;

  // Occupancy counts reads already in flight so a stalled
  // consumer can never overflow the two FIFO slots.
  always_comb begin
    pop   = (cnt_q != 2'd0) && bus.Out_Ready;
    push  = inflight_q;
    occ   = {1'b0, cnt_q}
          + {2'b00, inflight_q}
          - {2'b00, pop};
    issue = (state_q == S_RUN) && (occ < 3'd2);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Go) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue && addr_q == LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0 && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The counter saturates at LAST; leaving RUN stops further reads.
  always_comb begin
    addr_d = addr_q;
    if (state_q == S_IDLE && Go) begin
      addr_d = '0;
    end else if (issue && addr_q != LAST) begin
      addr_d = addr_q + 1'b1;
    end
    p_addr_d   = issue ? addr_q : p_addr_q;
    inflight_d = issue;
  end

  // p_addr_q still holds the previous cycle's read address
  // when its data returns, so it doubles as the FIFO tag.
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: p_addr_q, data: bus.P_In};
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q
             + {1'b0, push}
             - {1'b0, pop};
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      addr_q     <= '0;
      p_addr_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      addr_q     <= addr_d;
      p_addr_q   <= p_addr_d;
      inflight_q <= inflight_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    Busy          = (state_q == S_RUN)
                 || (state_q == S_DRAIN);
    Done          = (state_q == S_DONE);
    bus.P_En      = issue;
    bus.P_We      = 1'b0;
    bus.P_Addr    = issue ? addr_q : p_addr_q;
    bus.Out_Valid = (cnt_q != 2'd0);
    bus.Out_Data  = fifo_q[rd_ptr_q].data;
    bus.Out_Addr  = fifo_q[rd_ptr_q].addr;
  end

endmodule

// File: tb/tb_sram_result_reader.sv
// Directed bench: scenario table of full sweeps plus reset sequences,
// with a behavioural P memory on the slave side of the bus.
module tb_sram_result_reader;

  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int NW     = 2048;
  localparam int BUDGET = 20000;

  localparam int M_ON     = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_RAND   = 2;
  localparam int M_STALL  = 3;

  typedef struct {
    int mode;
    int go_at;
    int rst_at;
    int exp_words;
    int exp_dones;
  } vec_t;

  logic clk;
  logic rst_n;
  logic go;
  logic busy;
  logic done;
  int   n_cmp;
  int   n_bad;

  logic [DW-1:0] mem [NW];
  vec_t          vecs [7];

  sram_result_reader_if #(
    .A_INIT_WIDTH(AW),
    .D_INIT_WIDTH(DW)
  ) bus ();

  sram_result_reader #(
    .A_INIT_WIDTH(AW),
    .D_INIT_WIDTH(DW)
  ) dut (
    .Clk  (clk),
    .Rst  (rst_n),
    .Go   (go),
    .Busy (busy),
    .Done (done),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.P_En) bus.P_In <= mem[bus.P_Addr];
  end

  function automatic logic [31:0] exp_data(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h01010101;
    if (i == NW - 1) v = 32'hDEADBEEF;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_p_en"}, 32'(bus.P_En), 32'd0);
    chk({tag, "_p_we"}, 32'(bus.P_We), 32'd0);
    chk({tag, "_p_addr"}, 32'(bus.P_Addr), 32'd0);
    chk({tag, "_valid"}, 32'(bus.Out_Valid), 32'd0);
    chk({tag, "_data"}, bus.Out_Data, 32'd0);
    chk({tag, "_oaddr"}, 32'(bus.Out_Addr), 32'd0);
  endtask

  task automatic run_sweep(input vec_t v);
    int   words;
    int   issued;
    int   dones;
    int   first_v;
    int   last_acc;
    int   done_cyc;
    int   stall_en;
    bit   go_sent;
    bit   finished;
    logic r;
    logic pv;
    logic pr;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    words     = 0;
    issued    = 0;
    dones     = 0;
    first_v   = -1;
    last_acc  = -1;
    done_cyc  = -1;
    stall_en  = 0;
    go_sent   = 1'b0;
    finished  = 1'b0;
    pv        = 1'b0;
    pr        = 1'b0;
    pd        = '0;
    pa        = '0;
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    go = 1'b1;
    bus.Out_Ready = (v.mode != M_STALL);
    for (int cyc = 1; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      if (v.rst_at >= 0 && words == v.rst_at) begin
        rst_n = 1'b0;
        bus.Out_Ready = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.Out_Valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("rst_dones", 32'(dones), 32'(v.exp_dones));
        return;
      end
      if (v.go_at >= 0 && words == v.go_at && !go_sent) begin
        go = 1'b1;
        go_sent = 1'b1;
      end
      if (pv && !pr) begin
        chk("hold_valid", 32'(bus.Out_Valid), 32'd1);
        chk("hold_addr", 32'(bus.Out_Addr), 32'(pa));
        chk("hold_data", bus.Out_Data, pd);
      end
      if (bus.Out_Valid && first_v < 0) first_v = cyc;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      case (v.mode)
        M_TOGGLE: r = ((cyc % 2) == 1);
        M_RAND:   r = ($urandom_range(0, 99) < 30);
        M_STALL:  r = (cyc > 100);
        default:  r = 1'b1;
      endcase
      bus.Out_Ready = r;
      #1;
      chk("p_we", 32'(bus.P_We), 32'd0);
      if (bus.P_En) begin
        chk("p_addr", 32'(bus.P_Addr), 32'(issued));
        chk("p_en_in_range", 32'(issued < NW), 32'd1);
        issued++;
        if (v.mode == M_STALL && cyc <= 100) stall_en++;
      end
      if (v.mode == M_STALL && cyc == 100) begin
        chk("stall_reads", 32'(stall_en), 32'd2);
        chk("stall_valid", 32'(bus.Out_Valid), 32'd1);
        chk("stall_oaddr", 32'(bus.Out_Addr), 32'd0);
      end
      if (bus.Out_Valid && r) begin
        chk("word_addr", 32'(bus.Out_Addr), 32'(words));
        chk("word_data", bus.Out_Data, exp_data(words));
        last_addr = bus.Out_Addr;
        last_data = bus.Out_Data;
        last_acc  = cyc;
        words++;
      end
      pv = bus.Out_Valid;
      pr = r;
      pd = bus.Out_Data;
      pa = bus.Out_Addr;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout: got no Done want Done within %0d cycles",
               BUDGET);
    end
    chk("words", 32'(words), 32'(v.exp_words));
    chk("dones", 32'(dones), 32'(v.exp_dones));
    chk("first_valid_cyc", 32'(first_v), 32'd3);
    chk("done_after_last", 32'(done_cyc), 32'(last_acc + 2));
    chk("last_addr", 32'(last_addr), 32'h7FF);
    chk("last_data", last_data, 32'hDEADBEEF);
    chk("idle_busy", 32'(busy), 32'd0);
    if (v.mode == M_ON) begin
      chk("one_per_cycle", 32'(last_acc), 32'(3 + NW - 1));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    go    = 1'b0;
    bus.Out_Ready = 1'b0;
    bus.P_In = '0;
    for (int i = 0; i < NW; i++) mem[i] = exp_data(i);

    vecs[0] = '{M_ON,     -1,   -1, NW,   1};
    vecs[1] = '{M_TOGGLE, -1,   -1, NW,   1};
    vecs[2] = '{M_RAND,   -1,   -1, NW,   1};
    vecs[3] = '{M_STALL,  -1,   -1, NW,   1};
    vecs[4] = '{M_ON,     500,  -1, NW,   1};
    vecs[5] = '{M_ON,     -1, 1000, 1000, 0};
    vecs[6] = '{M_ON,     -1,   -1, NW,   1};

    repeat (2) @(negedge clk);
    check_reset_vals("init");
    go = 1'b1;
    @(negedge clk);
    chk("go_in_reset_busy", 32'(busy), 32'd0);
    go = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", 32'(bus.Out_Valid), 32'd0);
    chk("idle_p_en", 32'(bus.P_En), 32'd0);

    for (int k = 0; k < 7; k++) begin
      run_sweep(vecs[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
